button_press_decoder: RTL and testbench

//  Consumes the debounced level and edge pulses of one front-panel button and

---
 rtl/button_press_decoder_pkg.sv | 7 +
 rtl/button_press_decoder.sv | 67 ++++++
 tb/tb_button_press_decoder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/button_press_decoder_pkg.sv
// button_press_decoder_pkg: user-event codes shared with the time-set FSM
package button_press_decoder_pkg;
  localparam logic [1:0] EV_NONE   = 2'd0;
  localparam logic [1:0] EV_SHORT  = 2'd1;
  localparam logic [1:0] EV_LONG   = 2'd2;
  localparam logic [1:0] EV_REPEAT = 2'd3;
endpackage

// File: rtl/button_press_decoder.sv
// button_press_decoder: classifies debounced button activity into short/long/repeat events
module button_press_decoder
  import button_press_decoder_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 100_000_000,
  parameter int unsigned REPEAT_CYCLES = 25_000_000,
  parameter int unsigned CNT_W         = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic pressed,
  input  logic pressEdge,
  input  logic releaseEdge,
  output logic shortPress,
  output logic longPress,
  output logic repeatPulse,
  output logic held
);
  typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_HELD} state_t;
  if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
    $error("HOLD_CYCLES and REPEAT_CYCLES must both be >= 2");
  end
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ev_q, ev_d;
  logic             rel;
  assign rel = releaseEdge || !pressed;
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    ev_d    = EV_NONE;
    case (state_q)
      S_IDLE:    state_d = (pressEdge && !releaseEdge) ? S_PRESSED : S_IDLE;
      S_PRESSED: begin
        if (rel) begin
          state_d = S_IDLE;
          ev_d    = releaseEdge ? EV_SHORT : EV_NONE;
        end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d = S_HELD;
          ev_d    = EV_LONG;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      S_HELD: begin
        // a release always beats a repeat that falls due on the same edge
        if (rel) state_d = S_IDLE;
        else if (cnt_q == CNT_W'(REPEAT_CYCLES - 1)) ev_d = EV_REPEAT;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      default:   state_d = S_IDLE;
    endcase
  end
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ev_q    <= EV_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ev_q    <= ev_d;
    end
  end
  assign shortPress  = ev_q == EV_SHORT;
  assign longPress   = ev_q == EV_LONG;
  assign repeatPulse = ev_q == EV_REPEAT;
  assign held        = state_q == S_HELD;
endmodule

// File: tb/tb_button_press_decoder.sv
// tb_button_press_decoder: directed scenarios checked against an elapsed-time model
module tb_button_press_decoder;
  localparam int HOLD = 10;
  localparam int REP  = 4;
  logic clk = 1'b1;
  logic reset = 1'b1;
  logic pressed = 1'b0, pressEdge = 1'b0, releaseEdge = 1'b0;
  logic shortPress, longPress, repeatPulse, held;
  int tests = 0, fails = 0;
  bit active = 0;
  int p = 0;
  logic [3:0] exp_v = '0;
  logic [3:0] out_v;
  assign out_v = {shortPress, longPress, repeatPulse, held};
  button_press_decoder #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .pressed(pressed), .pressEdge(pressEdge),
    .releaseEdge(releaseEdge), .shortPress(shortPress), .longPress(longPress),
    .repeatPulse(repeatPulse), .held(held)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got {short,long,rep,held}=%b expected %b at %0t", nm, act, exp, $time);
    end
  endtask
  // model: p counts falling edges since the accepted press edge
  always @(negedge clk) begin
    exp_v = '0;
    if (reset) begin
      active = 0;
      p = 0;
    end else if (!active) begin
      if (pressEdge && !releaseEdge) begin
        active = 1;
        p = 0;
      end
    end else begin
      p++;
      if (releaseEdge || !pressed) begin
        active = 0;
        exp_v[3] = releaseEdge && p <= HOLD;
      end else if (p == HOLD) exp_v[2] = 1'b1;
      else if (p > HOLD && (p - HOLD) % REP == 0) exp_v[1] = 1'b1;
    end
    exp_v[0] = active && p >= HOLD;
    #2;
    chk("model", out_v, reset ? 4'b0000 : exp_v);
  end
  task automatic step(input logic pe, input logic re, input logic pr);
    pressEdge = pe;
    releaseEdge = re;
    pressed = pr;
    @(negedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end
  initial begin
    @(negedge clk); @(negedge clk); #1;
    chk("reset_state", out_v, 4'b0000);
    reset = 1'b0;
    idle(2);
    // 1: short press released at edge 5
    for (int e = 0; e <= 6; e++) begin
      step(e == 0, e == 5, e < 5);
      if (e == 5) chk("t1_short", out_v, 4'b1000);
      if (e == 6) chk("t1_after", out_v, 4'b0000);
    end
    idle(2);
    // 2: hold through edge 30, release at 31
    for (int e = 0; e <= 31; e++) begin
      step(e == 0, e == 31, e < 31);
      if (e == 9)  chk("t2_pre_long", out_v, 4'b0000);
      if (e == 10) chk("t2_long", out_v, 4'b0101);
      if (e == 13) chk("t2_held", out_v, 4'b0001);
      if (e == 14) chk("t2_rep14", out_v, 4'b0011);
      if (e == 15) chk("t2_rep_off", out_v, 4'b0001);
      if (e == 30) chk("t2_rep30", out_v, 4'b0011);
      if (e == 31) chk("t2_release", out_v, 4'b0000);
    end
    idle(2);
    // 3: release coincides with the hold threshold
    for (int e = 0; e <= 10; e++) begin
      step(e == 0, e == 10, e < 10);
      if (e == 10) chk("t3_release_wins", out_v, 4'b1000);
    end
    idle(2);
    // 4: reset during a hold, button still down afterwards
    for (int e = 0; e <= 11; e++) step(e == 0, 0, 1);
    chk("t4_held_before", out_v, 4'b0001);
    reset = 1'b1;
    #1;
    chk("t4_async_clear", out_v, 4'b0000);
    for (int e = 0; e < 3; e++) step(0, 0, 1);
    reset = 1'b0;
    for (int e = 0; e < 12; e++) step(0, 0, 1);
    chk("t4_no_events", out_v, 4'b0000);
    step(0, 1, 0);
    chk("t4_release_ignored", out_v, 4'b0000);
    for (int e = 0; e <= 3; e++) begin
      step(e == 0, e == 3, e < 3);
      if (e == 3) chk("t4_fresh_short", out_v, 4'b1000);
    end
    idle(2);
    // 5: missed release, then a fresh count
    for (int e = 0; e <= 3; e++) begin
      step(e == 0, 0, e < 3);
      if (e == 3) chk("t5_missed", out_v, 4'b0000);
    end
    idle(2);
    for (int e = 0; e <= 12; e++) begin
      step(e == 0, e == 12, e < 12);
      if (e == 10) chk("t5_fresh_long", out_v, 4'b0101);
      if (e == 12) chk("t5_release", out_v, 4'b0000);
    end
    idle(2);
    // 6: stray pressEdge mid-press
    for (int e = 0; e <= 18; e++) begin
      step(e == 0 || e == 4, e == 16, e < 16);
      if (e == 10) chk("t6_long", out_v, 4'b0101);
      if (e == 14) chk("t6_rep", out_v, 4'b0011);
      if (e == 16) chk("t6_release", out_v, 4'b0000);
      if (e == 18) chk("t6_quiet", out_v, 4'b0000);
    end
    // simultaneous press/release in IDLE is a release and is ignored
    step(1, 1, 0);
    idle(3);
    chk("both_edges_idle", out_v, 4'b0000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
